// File: rtl/cheri_cap_guard.sv
// +----------------------------------------------------------------------------+
// | cheri_cap_guard: capability bounds/permission check with trap latch        |
// | Optional: CAP_ALIGN_CHECK_EN adds a natural-alignment fault (cause 6).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cheri_cap_guard #(
  parameter int XLEN   = 32,
  parameter int CIDX_W = 2,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_we,
  input  logic [CIDX_W-1:0] cap_widx,
  input  logic              cap_wtag,
  input  logic [XLEN-1:0]   cap_wbase,
  input  logic [XLEN-1:0]   cap_wlength,
  input  logic [2:0]        cap_wperm,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CIDX_W-1:0] req_idx,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_load,
  input  logic              req_store,
  input  logic              req_exec,
  input  logic [XLEN-1:0]   req_pc,
  output logic              rsp_valid,
  output logic              rsp_ok,
  output logic [2:0]        rsp_cause,
  output logic              trap,
  output logic [2:0]        trap_cause,
  output logic [XLEN-1:0]   trap_epc,
  output logic [XLEN-1:0]   trap_addr,
  input  logic              trap_clr,
  output logic [FCNT_W-1:0] fault_cnt
);

  localparam int NUM_CAPS = 1 << CIDX_W;

  localparam logic [2:0] c_CAUSE_NONE  = 3'd0;
  localparam logic [2:0] c_CAUSE_TAG   = 3'd1;
  localparam logic [2:0] c_CAUSE_LOAD  = 3'd2;
  localparam logic [2:0] c_CAUSE_STORE = 3'd3;
  localparam logic [2:0] c_CAUSE_EXEC  = 3'd4;
  localparam logic [2:0] c_CAUSE_BNDS  = 3'd5;
`ifdef CAP_ALIGN_CHECK_EN
  localparam logic [2:0] c_CAUSE_ALGN  = 3'd6;
`endif

  logic [NUM_CAPS-1:0]           r_tag;
  logic [NUM_CAPS-1:0][XLEN-1:0] r_base;
  logic [NUM_CAPS-1:0][XLEN-1:0] r_len;
  logic [NUM_CAPS-1:0][2:0]      r_perm;

  logic              r_rsp_valid;
  logic              r_rsp_ok;
  logic [2:0]        r_rsp_cause;
  logic              r_trap;
  logic [2:0]        r_trap_cause;
  logic [XLEN-1:0]   r_trap_epc;
  logic [XLEN-1:0]   r_trap_addr;
  logic [FCNT_W-1:0] r_fcnt;

  logic            w_accept;
  logic            w_any_right;
  logic [2:0]      w_perm;
  logic [XLEN:0]   w_span;
  logic [XLEN:0]   w_top;
  logic [XLEN:0]   w_end;
  logic            w_in_bounds;
  logic [2:0]      w_cause;

  assign w_accept    = req_valid & ~r_trap;
  assign w_any_right = req_load | req_store | req_exec;
  assign w_perm      = r_perm[req_idx];

  // Bounds are evaluated one bit wider than XLEN so top/end never wrap.
  assign w_span      = (XLEN+1)'(4'd1 << req_size);
  assign w_top       = {1'b0, r_base[req_idx]} + {1'b0, r_len[req_idx]};
  assign w_end       = {1'b0, req_addr} + w_span;
  assign w_in_bounds = (req_addr >= r_base[req_idx]) && (w_end <= w_top);

`ifdef CAP_ALIGN_CHECK_EN
  logic w_misaligned;
  // Size 3 gives w_span[2:0] = 0, so the mask wraps to 3'b111 as required.
  assign w_misaligned = |(req_addr[2:0] & (w_span[2:0] - 3'd1));
`endif

  always_comb begin
    w_cause = c_CAUSE_NONE;
    if (w_any_right) begin
      if (!r_tag[req_idx])                w_cause = c_CAUSE_TAG;
      else if (req_load  && !w_perm[0])   w_cause = c_CAUSE_LOAD;
      else if (req_store && !w_perm[1])   w_cause = c_CAUSE_STORE;
      else if (req_exec  && !w_perm[2])   w_cause = c_CAUSE_EXEC;
      else if (!w_in_bounds)              w_cause = c_CAUSE_BNDS;
`ifdef CAP_ALIGN_CHECK_EN
      else if (w_misaligned)              w_cause = c_CAUSE_ALGN;
`endif
    end
  end

  // A check in the same cycle as a write to its index sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CAPS; i++) begin
        r_tag[i]  <= (i == 0);
        r_base[i] <= '0;
        r_len[i]  <= (i == 0) ? '1 : '0;
        r_perm[i] <= (i == 0) ? 3'b111 : 3'b000;
      end
    end else if (cap_we) begin
      r_tag[cap_widx]  <= cap_wtag;
      r_base[cap_widx] <= cap_wbase;
      r_len[cap_widx]  <= cap_wlength;
      r_perm[cap_widx] <= cap_wperm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_ok     <= 1'b0;
      r_rsp_cause  <= c_CAUSE_NONE;
      r_trap       <= 1'b0;
      r_trap_cause <= c_CAUSE_NONE;
      r_trap_epc   <= '0;
      r_trap_addr  <= '0;
      r_fcnt       <= '0;
    end else begin
      r_rsp_valid <= w_accept;
      r_rsp_ok    <= w_accept && (w_cause == c_CAUSE_NONE);
      r_rsp_cause <= w_accept ? w_cause : c_CAUSE_NONE;
      if (w_accept && (w_cause != c_CAUSE_NONE)) begin
        r_trap       <= 1'b1;
        r_trap_cause <= w_cause;
        r_trap_epc   <= req_pc;
        r_trap_addr  <= req_addr;
        if (r_fcnt != '1) r_fcnt <= r_fcnt + FCNT_W'(1);
      end else if (trap_clr && r_trap) begin
        r_trap <= 1'b0;
      end
    end
  end

  assign req_ready  = ~r_trap;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_ok     = r_rsp_ok;
  assign rsp_cause  = r_rsp_cause;
  assign trap       = r_trap;
  assign trap_cause = r_trap_cause;
  assign trap_epc   = r_trap_epc;
  assign trap_addr  = r_trap_addr;
  assign fault_cnt  = r_fcnt;

endmodule

`default_nettype wire

// File: tb/tb_cheri_cap_guard.sv
// +----------------------------------------------------------------------------+
// | tb_cheri_cap_guard: scoreboard bench with a rule-level reference model     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cheri_cap_guard;

  localparam int XLEN   = 32;
  localparam int CIDX_W = 2;
  localparam int FCNT_W = 2;
  localparam int FMAX   = (1 << FCNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              cap_we;
  logic [CIDX_W-1:0] cap_widx;
  logic              cap_wtag;
  logic [XLEN-1:0]   cap_wbase;
  logic [XLEN-1:0]   cap_wlength;
  logic [2:0]        cap_wperm;
  logic              req_valid;
  logic              req_ready;
  logic [CIDX_W-1:0] req_idx;
  logic [XLEN-1:0]   req_addr;
  logic [1:0]        req_size;
  logic              req_load;
  logic              req_store;
  logic              req_exec;
  logic [XLEN-1:0]   req_pc;
  logic              rsp_valid;
  logic              rsp_ok;
  logic [2:0]        rsp_cause;
  logic              trap;
  logic [2:0]        trap_cause;
  logic [XLEN-1:0]   trap_epc;
  logic [XLEN-1:0]   trap_addr;
  logic              trap_clr;
  logic [FCNT_W-1:0] fault_cnt;

  cheri_cap_guard #(.XLEN(XLEN), .CIDX_W(CIDX_W), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .rst(rst),
    .cap_we(cap_we), .cap_widx(cap_widx), .cap_wtag(cap_wtag),
    .cap_wbase(cap_wbase), .cap_wlength(cap_wlength), .cap_wperm(cap_wperm),
    .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
    .req_addr(req_addr), .req_size(req_size), .req_load(req_load),
    .req_store(req_store), .req_exec(req_exec), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_cause(rsp_cause),
    .trap(trap), .trap_cause(trap_cause), .trap_epc(trap_epc),
    .trap_addr(trap_addr), .trap_clr(trap_clr), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int q[$];

  // Reference state: the capability bank and the trap record as plain values.
  bit          m_tag  [4];
  longint      m_base [4];
  longint      m_len  [4];
  bit [2:0]    m_perm [4];
  bit          m_trap;
  int          m_tcause;
  longint      m_epc;
  longint      m_taddr;
  int          m_cnt;

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_tag[i]  = (i == 0);
      m_base[i] = 0;
      m_len[i]  = (i == 0) ? 64'hFFFF_FFFF : 0;
      m_perm[i] = (i == 0) ? 3'b111 : 3'b000;
    end
    m_trap = 0; m_tcause = 0; m_epc = 0; m_taddr = 0; m_cnt = 0;
  endtask

  function automatic int ref_cause(int idx, longint addr, int size, bit l, bit s, bit x);
    longint span;
    span = longint'(1) << size;
    if (!(l || s || x))                             return 0;
    if (!m_tag[idx])                                return 1;
    if (l && !m_perm[idx][0])                       return 2;
    if (s && !m_perm[idx][1])                       return 3;
    if (x && !m_perm[idx][2])                       return 4;
    if (addr < m_base[idx] || addr + span > m_base[idx] + m_len[idx]) return 5;
`ifdef CAP_ALIGN_CHECK_EN
    if (addr % span != 0)                           return 6;
`endif
    return 0;
  endfunction

  // Advance the model by one clock edge with the inputs currently driven,
  // then compare the architectural state after that edge.
  task automatic tick();
    int c;
    if (rst) begin
      model_reset();
    end else begin
      if (req_valid && !m_trap) begin
        c = ref_cause(int'(req_idx), longint'(req_addr), int'(req_size),
                      req_load, req_store, req_exec);
        q.push_back(c);
        if (c != 0) begin
          m_trap = 1; m_tcause = c;
          m_epc = longint'(req_pc); m_taddr = longint'(req_addr);
          if (m_cnt < FMAX) m_cnt++;
        end
      end else if (trap_clr && m_trap) begin
        m_trap = 0;
      end
      if (cap_we) begin
        m_tag[cap_widx]  = cap_wtag;
        m_base[cap_widx] = longint'(cap_wbase);
        m_len[cap_widx]  = longint'(cap_wlength);
        m_perm[cap_widx] = cap_wperm;
      end
    end
    @(negedge clk);
    chk("req_ready",  req_ready,  !m_trap);
    chk("trap",       trap,       m_trap);
    chk("trap_cause", trap_cause, m_tcause);
    chk("trap_epc",   trap_epc,   m_epc);
    chk("trap_addr",  trap_addr,  m_taddr);
    chk("fault_cnt",  fault_cnt,  m_cnt);
    rst = 0; req_valid = 0; cap_we = 0; trap_clr = 0;
  endtask

  task automatic req(int idx, logic [31:0] a, int sz, bit l, bit s, bit x, logic [31:0] pc);
    req_valid = 1; req_idx = 2'(idx); req_addr = a; req_size = 2'(sz);
    req_load = l; req_store = s; req_exec = x; req_pc = pc;
  endtask

  task automatic wr(int idx, bit t, logic [31:0] b, logic [31:0] len, logic [2:0] p);
    cap_we = 1; cap_widx = 2'(idx); cap_wtag = t;
    cap_wbase = b; cap_wlength = len; cap_wperm = p;
  endtask

  // Monitor: every response the DUT presents is matched against the queue.
  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      if (rsp_valid === 1'b1) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected: actual=rsp_valid required=no response");
        end else begin
          e = q.pop_front();
          chk("rsp_ok",    rsp_ok,    (e == 0));
          chk("rsp_cause", rsp_cause, e);
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          ix;
    rst = 1; cap_we = 0; cap_widx = 0; cap_wtag = 0; cap_wbase = 0;
    cap_wlength = 0; cap_wperm = 0; req_valid = 0; req_idx = 0; req_addr = 0;
    req_size = 0; req_load = 0; req_store = 0; req_exec = 0; req_pc = 0;
    trap_clr = 0;
    model_reset();
    tick();
    rst = 1;
    tick();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_ok",    rsp_ok,    0);
    chk("rst_rsp_cause", rsp_cause, 0);

    req(0, 32'h1000, 2, 1, 0, 0, 32'h80);          tick();
    wr(1, 1, 32'h2000, 32'h10, 3'b011);            tick();
    req(1, 32'h200C, 2, 0, 1, 0, 32'h100);         tick();
    req(1, 32'h200D, 2, 0, 1, 0, 32'h104);         tick();
    req(0, 32'h1000, 2, 1, 0, 0, 32'h108);         tick();  // blocked by trap
    trap_clr = 1;                                  tick();
    req(2, 32'h0, 2, 0, 0, 1, 32'h10C);            tick();
    trap_clr = 1;                                  tick();
    req(1, 32'h3000, 2, 0, 0, 1, 32'h110);         tick();
    trap_clr = 1;                                  tick();
    wr(3, 1, 32'h0, 32'hFFFF_FFFF, 3'b111);
    req(3, 32'h40, 2, 1, 0, 0, 32'h114);           tick();
    trap_clr = 1;                                  tick();
    req(3, 32'h40, 2, 1, 0, 0, 32'h118);           tick();
    trap_clr = 1;                                  tick();  // ignored, no trap
    req(0, 32'hFFFF_FFFF, 0, 1, 0, 0, 32'h11C);    tick();
    trap_clr = 1;                                  tick();
    req(0, 32'hFFFF_FFFC, 2, 1, 0, 0, 32'h120);    tick();
    trap_clr = 1;                                  tick();
    req(0, 32'h1002, 2, 1, 0, 0, 32'h124);         tick();
    trap_clr = 1;                                  tick();
    req(2, 32'h5, 3, 0, 0, 0, 32'h128);            tick();
    req(0, 32'hFFFF_FFF8, 3, 1, 1, 1, 32'h12C);    tick();
    req(0, 32'h10, 1, 0, 1, 0, 32'h130);           tick();
    rst = 1; req(2, 32'h0, 0, 1, 0, 0, 32'h134);   tick();  // reset discards it

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) rst = 1;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       a = $urandom_range(0, 64);
          1:       a = $urandom;
          default: a = 32'hFFFF_FFFF;
        endcase
        wr(int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
           $urandom & 32'hFFFF_FFF0, a, 3'($urandom_range(0, 7)));
      end
      if (m_trap) trap_clr = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) != 0) begin
        ix = int'($urandom_range(0, 3));
        case ($urandom_range(0, 2))
          0:       a = 32'(m_base[ix]) + 32'($urandom_range(0, 12)) - 32'd4;
          1:       a = 32'(m_base[ix] + m_len[ix]) - 32'($urandom_range(0, 12));
          default: a = $urandom;
        endcase
        req(ix, a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end
      tick();
    end

    repeat (3) tick();
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
